apb_master_bridge: RTL and testbench

APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

---
 rtl/apb_pkg.sv | 18 +
 rtl/apb_timeout_counter.sv | 31 +++
 rtl/apb_master_bridge.sv | 141 ++++++++++++++
 tb/tb_apb_master_bridge.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions: master FSM state encoding and the default bus widths
// used by both the master bridge and the APB slave memory.
package apb_pkg;

  localparam int APB_ADDR_WIDTH = 8;
  localparam int APB_DATA_WIDTH = 32;
  localparam int APB_SEL_WIDTH  = 4;
  localparam int APB_TIMEOUT    = 16;
  localparam int APB_CNT_WIDTH  = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_mst_state_t;

endpackage

// File: rtl/apb_timeout_counter.sv
// ACCESS-phase wait counter; expire flags the last permitted wait cycle so the
// bridge can abort on the same edge the count would reach TIMEOUT.
module apb_timeout_counter
  import apb_pkg::*;
#(
  parameter int TIMEOUT = APB_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic expire
);

  logic [APB_CNT_WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 8'd1;
    end else begin
      count <= count;
    end
  end

  assign expire = (count == APB_CNT_WIDTH'(TIMEOUT - 1));

endmodule

// File: rtl/apb_master_bridge.sv
// Valid/ready command to APB master bridge with one outstanding transfer,
// access timeout and fully registered outputs.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH = APB_DATA_WIDTH,
  parameter int SEL_WIDTH  = APB_SEL_WIDTH,
  parameter int TIMEOUT    = APB_TIMEOUT
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_write,
  input  logic [ADDR_WIDTH-1:0]          req_addr,
  input  logic [DATA_WIDTH-1:0]          req_wdata,
  // One extra code point so out-of-range indices are expressible for power-of-two widths
  input  logic [$clog2(SEL_WIDTH+1)-1:0] req_sel_idx,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic [DATA_WIDTH-1:0]          resp_rdata,
  output logic                           resp_err,
  output logic                           resp_timeout,
  output logic [SEL_WIDTH-1:0]           sel,
  output logic                           enable,
  output logic                           write,
  output logic [ADDR_WIDTH-1:0]          addr,
  output logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH-1:0]          rdata,
  input  logic                           ready,
  input  logic                           slv_err
);

  localparam int IDX_W = $clog2(SEL_WIDTH + 1);

  apb_mst_state_t       state;
  logic [SEL_WIDTH-1:0] sel_dec;
  logic                 idx_ok;
  logic                 cnt_clear;
  logic                 cnt_inc;
  logic                 cnt_expire;

  always_comb begin
    sel_dec = '0;
    for (int i = 0; i < SEL_WIDTH; i++) begin
      sel_dec[i] = (req_sel_idx == IDX_W'(i));
    end
  end

  assign idx_ok    = (req_sel_idx < IDX_W'(SEL_WIDTH));
  assign cnt_clear = (state != ST_ACCESS);
  assign cnt_inc   = (state == ST_ACCESS) && !ready;

  apb_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear),
    .inc    (cnt_inc),
    .expire (cnt_expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      req_ready    <= 1'b1;
      sel          <= '0;
      enable       <= 1'b0;
      write        <= 1'b0;
      addr         <= '0;
      wdata        <= '0;
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      resp_err     <= 1'b0;
      resp_timeout <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            if (idx_ok) begin
              write <= req_write;
              addr  <= req_addr;
              wdata <= req_wdata;
              sel   <= sel_dec;
              state <= ST_SETUP;
            end else begin
              // Bad select never touches the bus; report an error immediately
              resp_valid   <= 1'b1;
              resp_rdata   <= '0;
              resp_err     <= 1'b1;
              resp_timeout <= 1'b0;
              state        <= ST_RESP;
            end
          end
        end
        ST_SETUP: begin
          enable <= 1'b1;
          state  <= ST_ACCESS;
        end
        ST_ACCESS: begin
          // ready takes priority over a simultaneous expiry
          if (ready) begin
            resp_valid   <= 1'b1;
            resp_rdata   <= write ? '0 : rdata;
            resp_err     <= slv_err;
            resp_timeout <= 1'b0;
            sel          <= '0;
            enable       <= 1'b0;
            state        <= ST_RESP;
          end else if (cnt_expire) begin
            resp_valid   <= 1'b1;
            resp_rdata   <= '0;
            resp_err     <= 1'b1;
            resp_timeout <= 1'b1;
            sel          <= '0;
            enable       <= 1'b0;
            state        <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: begin
          state      <= ST_IDLE;
          req_ready  <= 1'b1;
          sel        <= '0;
          enable     <= 1'b0;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed self-checking bench for apb_master_bridge with default parameters
// (ADDR 8, DATA 32, SEL 4, TIMEOUT 16).
module tb_apb_master_bridge;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_sel_idx;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        resp_timeout;
  logic [3:0]  sel;
  logic        enable;
  logic        write;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        slv_err;

  int          n_checks;
  int          n_fail;
  logic [31:0] mem_10;

  apb_master_bridge dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_sel_idx  (req_sel_idx),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .resp_timeout (resp_timeout),
    .sel          (sel),
    .enable       (enable),
    .write        (write),
    .addr         (addr),
    .wdata        (wdata),
    .rdata        (rdata),
    .ready        (ready),
    .slv_err      (slv_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a command for exactly one accepting edge, then withdraw it
  task automatic issue(input logic w, input logic [7:0] a, input logic [31:0] d, input logic [2:0] idx);
    chk("req_ready_before_issue", {31'd0, req_ready}, 32'd1);
    req_valid   = 1'b1;
    req_write   = w;
    req_addr    = a;
    req_wdata   = d;
    req_sel_idx = idx;
    tick();
    req_valid   = 1'b0;
  endtask

  task automatic consume;
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("resp_valid_after_consume", {31'd0, resp_valid}, 32'd0);
    chk("req_ready_after_consume", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    mem_10      = 32'd0;
    reset       = 1'b1;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_addr    = 8'h00;
    req_wdata   = 32'h0;
    req_sel_idx = 3'd0;
    resp_ready  = 1'b0;
    rdata       = 32'h0;
    ready       = 1'b0;
    slv_err     = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_sel", {28'd0, sel}, 32'd0);
    chk("rst_enable", {31'd0, enable}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_addr", {24'd0, addr}, 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    reset = 1'b0;
    tick();
    chk("idle_req_ready", {31'd0, req_ready}, 32'd1);

    // Write 0xDEADBEEF to 0x10 on slave 0, ready in first ACCESS cycle
    ready = 1'b1;
    issue(1'b1, 8'h10, 32'hDEADBEEF, 3'd0);
    chk("wr_setup_sel", {28'd0, sel}, 32'h1);
    chk("wr_setup_enable", {31'd0, enable}, 32'd0);
    chk("wr_setup_write", {31'd0, write}, 32'd1);
    chk("wr_setup_addr", {24'd0, addr}, 32'h10);
    chk("wr_setup_req_ready", {31'd0, req_ready}, 32'd0);
    tick();
    chk("wr_access_sel", {28'd0, sel}, 32'h1);
    chk("wr_access_enable", {31'd0, enable}, 32'd1);
    chk("wr_access_wdata", wdata, 32'hDEADBEEF);
    chk("wr_access_resp_valid", {31'd0, resp_valid}, 32'd0);
    if (write && enable && sel[0] && addr == 8'h10) mem_10 = wdata;
    tick();
    chk("wr_resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("wr_resp_err", {31'd0, resp_err}, 32'd0);
    chk("wr_resp_rdata", resp_rdata, 32'd0);
    chk("wr_resp_sel", {28'd0, sel}, 32'd0);
    chk("wr_resp_enable", {31'd0, enable}, 32'd0);
    consume();

    // Read back 0x10
    rdata = mem_10;
    issue(1'b0, 8'h10, 32'h0, 3'd0);
    chk("rd_setup_write", {31'd0, write}, 32'd0);
    tick();
    tick();
    chk("rd_resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("rd_resp_rdata", resp_rdata, 32'hDEADBEEF);
    chk("rd_resp_err", {31'd0, resp_err}, 32'd0);
    consume();

    // Five wait cycles then slave error with data
    ready = 1'b0;
    rdata = 32'h0;
    issue(1'b0, 8'h20, 32'h0, 3'd1);
    chk("ws_setup_sel", {28'd0, sel}, 32'h2);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("ws_wait_enable", {31'd0, enable}, 32'd1);
      chk("ws_wait_sel", {28'd0, sel}, 32'h2);
      chk("ws_wait_addr", {24'd0, addr}, 32'h20);
      chk("ws_wait_resp_valid", {31'd0, resp_valid}, 32'd0);
      tick();
    end
    chk("ws_last_enable", {31'd0, enable}, 32'd1);
    ready   = 1'b1;
    rdata   = 32'h1234;
    slv_err = 1'b1;
    tick();
    ready   = 1'b0;
    slv_err = 1'b0;
    rdata   = 32'h0;
    chk("ws_resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("ws_resp_rdata", resp_rdata, 32'h1234);
    chk("ws_resp_err", {31'd0, resp_err}, 32'd1);
    chk("ws_resp_timeout", {31'd0, resp_timeout}, 32'd0);
    consume();

    // Slave never ready: abort after 16 ACCESS cycles
    issue(1'b0, 8'h30, 32'h0, 3'd2);
    tick();
    for (int i = 1; i < 16; i++) begin
      chk("to_wait_enable", {31'd0, enable}, 32'd1);
      chk("to_wait_resp_valid", {31'd0, resp_valid}, 32'd0);
      tick();
    end
    chk("to_16th_enable", {31'd0, enable}, 32'd1);
    chk("to_16th_resp_valid", {31'd0, resp_valid}, 32'd0);
    tick();
    chk("to_resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("to_resp_err", {31'd0, resp_err}, 32'd1);
    chk("to_resp_timeout", {31'd0, resp_timeout}, 32'd1);
    chk("to_resp_rdata", resp_rdata, 32'd0);
    chk("to_resp_sel", {28'd0, sel}, 32'd0);
    consume();

    // Ready arrives on the 16th ACCESS cycle: completes without timeout
    issue(1'b0, 8'h34, 32'h0, 3'd2);
    tick();
    for (int i = 1; i < 16; i++) tick();
    chk("edge_16th_enable", {31'd0, enable}, 32'd1);
    ready = 1'b1;
    rdata = 32'hA5A5;
    tick();
    ready = 1'b0;
    rdata = 32'h0;
    chk("edge_resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("edge_resp_timeout", {31'd0, resp_timeout}, 32'd0);
    chk("edge_resp_err", {31'd0, resp_err}, 32'd0);
    chk("edge_resp_rdata", resp_rdata, 32'hA5A5);
    consume();

    // Response back-pressure with a new command waiting
    ready = 1'b1;
    issue(1'b1, 8'h44, 32'h55AA, 3'd3);
    chk("bp_setup_sel", {28'd0, sel}, 32'h8);
    tick();
    tick();
    ready       = 1'b0;
    req_valid   = 1'b1;
    req_write   = 1'b0;
    req_addr    = 8'h50;
    req_sel_idx = 3'd1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
      chk("bp_resp_err", {31'd0, resp_err}, 32'd0);
      chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
      chk("bp_sel", {28'd0, sel}, 32'd0);
      chk("bp_enable", {31'd0, enable}, 32'd0);
      tick();
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    req_valid  = 1'b0;
    chk("bp_release_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("bp_release_req_ready", {31'd0, req_ready}, 32'd1);
    chk("bp_release_sel", {28'd0, sel}, 32'd0);
    tick();

    // Reset pulsed during ACCESS
    issue(1'b0, 8'h60, 32'h0, 3'd1);
    tick();
    chk("rs_access_enable", {31'd0, enable}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rs_sel", {28'd0, sel}, 32'd0);
    chk("rs_enable", {31'd0, enable}, 32'd0);
    chk("rs_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rs_req_ready", {31'd0, req_ready}, 32'd1);
    tick();
    chk("rs_after_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rs_after_req_ready", {31'd0, req_ready}, 32'd1);

    // Out-of-range select index
    issue(1'b1, 8'h70, 32'h1111, 3'd5);
    chk("oor_resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("oor_resp_err", {31'd0, resp_err}, 32'd1);
    chk("oor_resp_timeout", {31'd0, resp_timeout}, 32'd0);
    chk("oor_sel", {28'd0, sel}, 32'd0);
    chk("oor_enable", {31'd0, enable}, 32'd0);
    tick();
    chk("oor_hold_sel", {28'd0, sel}, 32'd0);
    consume();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
